// File: rtl/input_module_if.sv
// input_module_if -- ingress beat bus plus shared-cache write bus of one
// ingress port.
//   Ingress (toward the block): wr_sop, wr_eop, wr_vld, wr_data; wr_ready back.
//   Cache side: full_in per-destination full flags (toward the block);
//               wr_sel, wr_en, wr_ctrl, cache_data (from the block).
// slave  modport: the ingress block itself.
// master modport: the environment (packet source plus cache).

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif
`ifndef PRIORITY
`define PRIORITY 8
`endif
`ifndef DATA_LENGTH_MAX
`define DATA_LENGTH_MAX 256
`endif
`ifndef CRC32_LENGTH
`define CRC32_LENGTH 16
`endif

interface input_module_if;
  localparam int DW = `DATA_WIDTH;
  localparam int PN = `PORT_NUB_TOTAL;
  localparam int WS = $clog2(`PORT_NUB_TOTAL);

  logic          wr_sop;
  logic          wr_eop;
  logic          wr_vld;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [PN-1:0] full_in;
  logic [WS-1:0] wr_sel;
  logic          wr_en;
  logic          wr_ctrl;
  logic [DW-1:0] cache_data;

  modport slave (
    input  wr_sop, wr_eop, wr_vld, wr_data, full_in,
    output wr_ready, wr_sel, wr_en, wr_ctrl, cache_data
  );

  modport master (
    output wr_sop, wr_eop, wr_vld, wr_data, full_in,
    input  wr_ready, wr_sel, wr_en, wr_ctrl, cache_data
  );
endinterface

// File: rtl/input_module.sv
// input_module -- store-and-forward ingress port.
// Receives a header beat followed by `length` payload beats, buffers the
// payload and its CRC, then writes one control word and the payload to the
// shared cache slot of the header's destination. Malformed packets are
// discarded and counted.
// Ports:
//   clk       sole clock
//   rst_n     asynchronous active-low reset
//   bus       input_module_if.slave (ingress beats, cache write bus)
//   drop_cnt  saturating count of dropped packets
// crc16_32bit -- CRC-16 (poly 0x1021, init 0xFFFF), one full word per cycle,
// word folded MSB first.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif
`ifndef PRIORITY
`define PRIORITY 8
`endif
`ifndef DATA_LENGTH_MAX
`define DATA_LENGTH_MAX 256
`endif
`ifndef CRC32_LENGTH
`define CRC32_LENGTH 16
`endif

module crc16_32bit #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          vld_i,
  input  logic [DW-1:0] data_i,
  output logic [15:0]   crc_o
);
  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] INIT = 16'hFFFF;

  logic [15:0] crc_q, crc_d;

  always_comb begin
    logic          fb;
    logic [DW-1:0] d;
    crc_d = crc_q;
    fb    = 1'b0;
    d     = data_i;
    if (clr_i) begin
      crc_d = INIT;
    end else if (vld_i) begin
      for (int unsigned i = 0; i < DW; i++) begin
        fb    = crc_d[15] ^ d[DW-1];
        crc_d = {crc_d[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        d     = d << 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= INIT;
    else        crc_q <= crc_d;
  end

  assign crc_o = crc_q;
endmodule

module input_module #(
  parameter int NUB = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input_module_if.slave bus,
  output logic [15:0]   drop_cnt
);
  localparam int DATA_WIDTH     = `DATA_WIDTH;
  localparam int WIDTH_SEL      = $clog2(`PORT_NUB_TOTAL);
  localparam int WIDTH_PRIORITY = $clog2(`PRIORITY);
  localparam int WIDTH_LENGTH   = $clog2(`DATA_LENGTH_MAX);
  localparam int WIDTH_CRC      = `CRC32_LENGTH;
  localparam int FIFO_DEPTH     = 1 << WIDTH_LENGTH;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RX      = 3'd1;
  localparam logic [2:0] TX_CTRL = 3'd2;
  localparam logic [2:0] TX_DATA = 3'd3;
  localparam logic [2:0] DROP    = 3'd4;

  if (NUB < 0 || NUB >= `PORT_NUB_TOTAL) begin : g_nub_check
    $error("input_module: NUB outside port range");
  end

  logic [2:0]                state_q, state_d;
  logic [WIDTH_SEL-1:0]      dest_q, dest_d;
  logic [WIDTH_PRIORITY-1:0] pri_q, pri_d;
  logic [WIDTH_LENGTH-1:0]   len_q, len_d;
  logic [WIDTH_LENGTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH_LENGTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [WIDTH_LENGTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]               drop_q, drop_d;
  logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];

  logic                      accept, push, crc_clr, crc_vld, drop_now;
  logic                      tx_active, dest_full, last_beat;
  logic [WIDTH_LENGTH-1:0]   hdr_len;
  logic [WIDTH_PRIORITY-1:0] hdr_pri;
  logic [WIDTH_SEL-1:0]      hdr_dest;
  logic [WIDTH_CRC-1:0]      crc;
  logic [DATA_WIDTH-1:0]     ctrl_word;

  crc16_32bit #(.DW(DATA_WIDTH)) u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (crc_clr),
    .vld_i  (crc_vld),
    .data_i (bus.wr_data),
    .crc_o  (crc)
  );

  assign hdr_len   = bus.wr_data[WIDTH_LENGTH-1:0];
  assign hdr_pri   = bus.wr_data[WIDTH_LENGTH +: WIDTH_PRIORITY];
  assign hdr_dest  = bus.wr_data[WIDTH_LENGTH+WIDTH_PRIORITY +: WIDTH_SEL];
  assign tx_active = (state_q == TX_CTRL) || (state_q == TX_DATA);
  assign dest_full = bus.full_in[dest_q];
  assign last_beat = (cnt_q + WIDTH_LENGTH'(1)) == len_q;
  assign accept    = bus.wr_vld && bus.wr_ready;

  // The CRC register folds in the eop word on the same edge that enters
  // TX_CTRL and is not touched again until the next header, so it is final
  // whenever the control word is issued.
  always_comb begin
    ctrl_word = '0;
    ctrl_word[WIDTH_PRIORITY-1:0]                       = pri_q;
    ctrl_word[WIDTH_PRIORITY +: WIDTH_CRC]              = crc;
    ctrl_word[WIDTH_PRIORITY+WIDTH_CRC +: WIDTH_LENGTH] = len_q;
  end

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    pri_d    = pri_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    push     = 1'b0;
    crc_clr  = 1'b0;
    crc_vld  = 1'b0;
    drop_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && bus.wr_sop) begin
          dest_d   = hdr_dest;
          pri_d    = hdr_pri;
          len_d    = hdr_len;
          cnt_d    = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          crc_clr  = 1'b1;
          if (hdr_len != '0)    state_d  = RX;
          else if (bus.wr_eop)  drop_now = 1'b1;
          else                  state_d  = DROP;
        end
      end
      RX: begin
        if (accept) begin
          if (bus.wr_sop) begin
            if (bus.wr_eop) drop_now = 1'b1;
            else            state_d  = DROP;
          end else if (bus.wr_eop) begin
            if (last_beat) begin
              push     = 1'b1;
              crc_vld  = 1'b1;
              wr_ptr_d = wr_ptr_q + WIDTH_LENGTH'(1);
              state_d  = TX_CTRL;
            end else begin
              drop_now = 1'b1;
            end
          end else if (last_beat) begin
            state_d = DROP;
          end else begin
            push     = 1'b1;
            crc_vld  = 1'b1;
            wr_ptr_d = wr_ptr_q + WIDTH_LENGTH'(1);
            cnt_d    = cnt_q + WIDTH_LENGTH'(1);
          end
        end
      end
      DROP: begin
        if (accept && bus.wr_eop) drop_now = 1'b1;
      end
      TX_CTRL: begin
        if (!dest_full) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (!dest_full) begin
          rd_ptr_d = rd_ptr_q + WIDTH_LENGTH'(1);
          if (rd_ptr_q == len_q - WIDTH_LENGTH'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (drop_now) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (drop_now && drop_q != '1) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dest_q   <= '0;
      pri_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      dest_q   <= dest_d;
      pri_q    <= pri_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.wr_data;
  end

  // wr_ready is gated by rst_n directly so it reads 0 for the whole reset
  // window and 1 as soon as reset is released.
  always_comb begin
    bus.wr_ready   = rst_n && !tx_active;
    bus.wr_en      = tx_active && !dest_full;
    bus.wr_ctrl    = (state_q == TX_CTRL) && !dest_full;
    bus.wr_sel     = tx_active ? dest_q : '0;
    bus.cache_data = '0;
    if (bus.wr_en) bus.cache_data = (state_q == TX_CTRL) ? ctrl_word : mem[rd_ptr_q];
  end

  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_input_module.sv
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif
`ifndef PRIORITY
`define PRIORITY 8
`endif
`ifndef DATA_LENGTH_MAX
`define DATA_LENGTH_MAX 256
`endif
`ifndef CRC32_LENGTH
`define CRC32_LENGTH 16
`endif

module tb_input_module;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] drop_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          exp_drops = 0;

  typedef struct {
    logic        ctrl;
    logic [2:0]  sel;
    logic [31:0] data;
    int          stamp;
  } word_t;

  typedef struct {
    logic [2:0] dest;
    logic [2:0] pri;
    int         len;
    int         nbeats;
    logic [7:0] full_mask;
    int         max_gap;
    logic       exp_fwd;
    int         exp_drop;
  } vec_t;

  word_t obs[$];
  word_t exp_q[$];
  vec_t  vecs[8];

  input_module_if bus();

  input_module #(.NUB(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: log every cache write and check bus-level invariants.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.wr_en === 1'b1) begin
        obs.push_back('{bus.wr_ctrl, bus.wr_sel, bus.cache_data, cyc});
        check("write_while_full", 64'(bus.full_in[bus.wr_sel]), 64'd0);
      end else begin
        check("idle_bus_zero", {31'd0, bus.wr_ctrl, bus.cache_data}, 64'd0);
      end
    end
  end

  function automatic logic [63:0] pk(input word_t w);
    return {28'd0, w.ctrl, w.sel, w.data};
  endfunction

  // Standard byte-oriented CRC-16/CCITT-FALSE over the payload, bytes taken
  // most significant first within each word.
  function automatic logic [15:0] ref_crc(input logic [31:0] pl[$]);
    logic [15:0] c;
    logic [31:0] w;
    logic [7:0]  b;
    c = 16'hFFFF;
    foreach (pl[k]) begin
      w = pl[k];
      for (int j = 3; j >= 0; j--) begin
        b = w[8*j +: 8];
        c = c ^ {b, 8'h00};
        for (int s = 0; s < 8; s++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] hdr(input logic [2:0] d, input logic [2:0] p, input int len);
    logic [31:0] h;
    logic [7:0]  l;
    h = $urandom;
    l = len[7:0];
    h[13:0] = {d, p, l};
    return h;
  endfunction

  task automatic expect_pkt(input logic [2:0] d, input logic [2:0] p, input int len,
                            input logic [31:0] pl[$]);
    logic [7:0] l;
    l = len[7:0];
    exp_q.push_back('{1'b1, d, {5'd0, l, ref_crc(pl), p}, 0});
    foreach (pl[k]) exp_q.push_back('{1'b0, d, pl[k], 0});
  endtask

  task automatic drive_beat(input logic sop, input logic eop, input logic [31:0] d);
    int guard = 0;
    while (bus.wr_ready !== 1'b1 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: wr_ready %b, expected 1", bus.wr_ready);
    end
    bus.wr_vld  = 1'b1;
    bus.wr_sop  = sop;
    bus.wr_eop  = eop;
    bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_vld  = 1'b0;
    bus.wr_sop  = 1'b0;
    bus.wr_eop  = 1'b0;
  endtask

  task automatic send_pkt(input logic [2:0] d, input logic [2:0] p, input int len,
                          input int nbeats, input int max_gap, output logic [31:0] pl[$]);
    logic [31:0] w;
    pl = {};
    drive_beat(1'b1, 1'b0, hdr(d, p, len));
    for (int i = 1; i <= nbeats; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      w = $urandom;
      pl.push_back(w);
      drive_beat(1'b0, i == nbeats, w);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (obs.size() < exp_q.size() && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic compare_out(input string tag);
    int n;
    check({tag, "_count"}, 64'(obs.size()), 64'(exp_q.size()));
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_word%0d", tag, i), pk(obs[i]), pk(exp_q[i]));
    obs.delete();
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pl[$];
    logic [31:0] pl2[$];
    vecs[0] = '{3'd3, 3'd5, 4,   4,   8'h00, 0, 1'b1, 0};
    vecs[1] = '{3'd3, 3'd5, 4,   3,   8'h00, 0, 1'b0, 1};
    vecs[2] = '{3'd1, 3'd2, 4,   4,   8'h00, 2, 1'b1, 0};
    vecs[3] = '{3'd0, 3'd0, 0,   1,   8'h00, 0, 1'b0, 1};
    vecs[4] = '{3'd7, 3'd7, 1,   1,   8'h00, 1, 1'b1, 0};
    vecs[5] = '{3'd2, 3'd3, 3,   5,   8'h00, 1, 1'b0, 1};
    vecs[6] = '{3'd5, 3'd1, 255, 255, 8'h00, 0, 1'b1, 0};
    vecs[7] = '{3'd6, 3'd4, 2,   2,   8'hBF, 0, 1'b1, 0};

    bus.wr_vld = 1'b0; bus.wr_sop = 1'b0; bus.wr_eop = 1'b0;
    bus.wr_data = '0; bus.full_in = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",   64'(bus.wr_ready),   64'd0);
    check("rst_en",      64'(bus.wr_en),      64'd0);
    check("rst_ctrl",    64'(bus.wr_ctrl),    64'd0);
    check("rst_sel",     64'(bus.wr_sel),     64'd0);
    check("rst_data",    64'(bus.cache_data), 64'd0);
    check("rst_dropcnt", 64'(drop_cnt),       64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(bus.wr_ready), 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      bus.full_in = vecs[i].full_mask;
      send_pkt(vecs[i].dest, vecs[i].pri, vecs[i].len, vecs[i].nbeats, vecs[i].max_gap, pl);
      if (vecs[i].exp_fwd) expect_pkt(vecs[i].dest, vecs[i].pri, vecs[i].len, pl);
      exp_drops += vecs[i].exp_drop;
      wait_drain();
      check($sformatf("vec%0d_forwarded", i), 64'(obs.size() != 0), 64'(vecs[i].exp_fwd));
      if (obs.size() != 0)
        check($sformatf("vec%0d_span", i), 64'(obs[obs.size()-1].stamp - obs[0].stamp), 64'(vecs[i].len));
      check($sformatf("vec%0d_dropcnt", i), 64'(drop_cnt), 64'(exp_drops));
      check($sformatf("vec%0d_ready", i), 64'(bus.wr_ready), 64'd1);
      compare_out($sformatf("vec%0d", i));
      bus.full_in = '0;
    end

    // wr_sop in the middle of a packet: one drop, then a clean packet.
    drive_beat(1'b1, 1'b0, hdr(3'd2, 3'd1, 4));
    drive_beat(1'b0, 1'b0, $urandom);
    drive_beat(1'b0, 1'b0, $urandom);
    drive_beat(1'b1, 1'b0, hdr(3'd4, 3'd1, 2));
    drive_beat(1'b0, 1'b1, $urandom);
    exp_drops++;
    send_pkt(3'd4, 3'd6, 3, 3, 0, pl);
    expect_pkt(3'd4, 3'd6, 3, pl);
    wait_drain();
    check("midsop_dropcnt", 64'(drop_cnt), 64'(exp_drops));
    compare_out("midsop");

    // Beats without wr_sop while idle are ignored.
    drive_beat(1'b0, 1'b0, $urandom);
    drive_beat(1'b0, 1'b1, $urandom);
    send_pkt(3'd0, 3'd3, 2, 2, 0, pl);
    expect_pkt(3'd0, 3'd3, 2, pl);
    wait_drain();
    check("junk_dropcnt", 64'(drop_cnt), 64'(exp_drops));
    compare_out("junk");

    // Destination full for 5 cycles after the first payload word.
    send_pkt(3'd3, 3'd2, 6, 6, 0, pl);
    expect_pkt(3'd3, 3'd2, 6, pl);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.full_in[3] = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    bus.full_in = '0;
    wait_drain();
    if (obs.size() != 0) check("stall_span", 64'(obs[obs.size()-1].stamp - obs[0].stamp), 64'd11);
    compare_out("stall");

    // Two packets back to back.
    send_pkt(3'd1, 3'd0, 3, 3, 0, pl);
    expect_pkt(3'd1, 3'd0, 3, pl);
    send_pkt(3'd2, 3'd7, 2, 2, 0, pl2);
    expect_pkt(3'd2, 3'd7, 2, pl2);
    wait_drain();
    compare_out("b2b");

    // Reset during payload beat 2 of 4.
    drive_beat(1'b1, 1'b0, hdr(3'd3, 3'd1, 4));
    drive_beat(1'b0, 1'b0, $urandom);
    bus.wr_vld = 1'b1;
    bus.wr_data = $urandom;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready",   64'(bus.wr_ready),   64'd0);
    check("midrst_en",      64'(bus.wr_en),      64'd0);
    check("midrst_sel",     64'(bus.wr_sel),     64'd0);
    check("midrst_data",    64'(bus.cache_data), 64'd0);
    check("midrst_dropcnt", 64'(drop_cnt),       64'd0);
    exp_drops = 0;
    @(posedge clk); #1;
    bus.wr_vld = 1'b0;
    rst_n = 1'b1;
    wait_drain();
    check("postrst_ready", 64'(bus.wr_ready), 64'd1);
    compare_out("midrst");
    send_pkt(3'd3, 3'd5, 4, 4, 0, pl);
    expect_pkt(3'd3, 3'd5, 4, pl);
    wait_drain();
    check("postrst_dropcnt", 64'(drop_cnt), 64'(exp_drops));
    compare_out("postrst");

    // Random traffic with random backpressure.
    begin
      bit done;
      done = 1'b0;
      fork
        begin
          logic [2:0] d, p;
          int len, nb, r;
          for (int k = 0; k < 40; k++) begin
            d = 3'($urandom_range(0, 7));
            p = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            len = (r == 0) ? 0 : $urandom_range(1, 12);
            nb = (r < 7 && len != 0) ? len : $urandom_range(1, len + 2);
            send_pkt(d, p, len, nb, 2, pl);
            if (len != 0 && nb == len) expect_pkt(d, p, len, pl);
            else exp_drops++;
          end
          done = 1'b1;
        end
        begin
          logic [31:0] t;
          while (!done) begin
            @(posedge clk); #1;
            t = $urandom;
            bus.full_in = t[7:0] & t[15:8];
          end
          bus.full_in = '0;
        end
      join
    end
    wait_drain();
    check("rand_dropcnt", 64'(drop_cnt), 64'(exp_drops));
    compare_out("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
